// File: rtl/recorder_pkg.sv
// Shared transport definitions for the audio recorder: mode and access-state
// encodings, SRAM address geometry and the playback rate normaliser.
package recorder_pkg;

    localparam int ADDR_W = 18;
    localparam logic [ADDR_W-1:0] MAX_ADDR = 18'h3FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        PAUSE  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_WR   = 2'd1,
        A_RD1  = 2'd2,
        A_RD2  = 2'd3
    } access_t;

    // Rate factors outside 1..8 mean "normal speed".
    function automatic logic [3:0] norm_rate(input logic [3:0] r);
        return (r == 4'd0 || r > 4'd8) ? 4'd1 : r;
    endfunction

endpackage

// File: rtl/speed_step.sv
// Playback pointer increment: fast skips F words per read, slow advances one
// word every S-th read using a sub-counter that survives pause/resume.
module speed_step
    import recorder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       step,
    input  logic [3:0] fast,
    input  logic [3:0] slow,
    output logic [3:0] inc
);

    logic [3:0] fast_n;
    logic [3:0] slow_n;
    logic [3:0] sub_cnt;
    logic       slow_wrap;
    logic       slow_active;

    always_comb begin
        fast_n      = norm_rate(fast);
        slow_n      = norm_rate(slow);
        slow_active = (fast_n == 4'd1) && (slow_n > 4'd1);
        slow_wrap   = (sub_cnt >= slow_n - 4'd1);
        inc         = 4'd1;
        if (fast_n > 4'd1) begin
            inc = fast_n;
        end else if (slow_active) begin
            inc = slow_wrap ? 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_cnt <= '0;
        end else if (clear) begin
            sub_cnt <= '0;
        end else if (step && slow_active) begin
            sub_cnt <= slow_wrap ? 4'd0 : sub_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/transport_ctrl.sv
// Transport sequencer and SRAM access scheduler: button-driven mode FSM plus
// a single-pointer write/read access FSM with a one-deep pending request.
module transport_ctrl
    import recorder_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_record,
    input  logic          btn_play,
    input  logic          btn_stop,
    input  logic [3:0]    fast,
    input  logic [3:0]    slow,
    input  logic          wr_req,
    input  logic          rd_req,
    output logic          wr_ack,
    output logic          rd_ack,
    output logic [AW-1:0] addr,
    output logic          sram_we,
    output logic          sram_oe,
    output logic [1:0]    mode,
    output logic [AW-1:0] end_addr,
    output logic          play_done
);

    localparam logic [AW-1:0] LAST = AW'(MAX_ADDR);

    mode_t         mode_q, mode_n;
    access_t       acc_q, acc_n;
    logic [2:0]    btn_q, btn_prev;
    logic          rec_e, play_e, stop_e;
    logic          pending_q, pending_n;
    logic [AW-1:0] addr_n, end_n;
    logic [AW:0]   next_ptr;
    logic          wr_ack_n;
    logic          wr_match, rd_match, req_m;
    logic          speed_clear, speed_adv;
    logic [3:0]    inc;

    assign rec_e  = btn_q[2] & ~btn_prev[2];
    assign play_e = btn_q[1] & ~btn_prev[1];
    assign stop_e = btn_q[0] & ~btn_prev[0];

    speed_step u_speed (
        .clk   (clk),
        .reset (reset),
        .clear (speed_clear),
        .step  (speed_adv),
        .fast  (fast),
        .slow  (slow),
        .inc   (inc)
    );

    always_comb begin
        mode_n      = mode_q;
        acc_n       = acc_q;
        pending_n   = pending_q;
        addr_n      = addr;
        end_n       = end_addr;
        wr_ack_n    = 1'b0;
        play_done   = 1'b0;
        speed_clear = 1'b0;
        speed_adv   = 1'b0;
        wr_match    = (mode_q == RECORD) && !stop_e;
        rd_match    = (mode_q == PLAY) && !stop_e && !play_e;
        req_m       = (wr_match && wr_req) || (rd_match && rd_req);
        next_ptr    = {1'b0, addr} + (AW+1)'(inc);

        case (acc_q)
            A_IDLE: begin
                if (wr_match && (pending_q || wr_req)) begin
                    acc_n     = A_WR;
                    pending_n = 1'b0;
                end else if (rd_match && (pending_q || rd_req)) begin
                    acc_n     = A_RD1;
                    pending_n = 1'b0;
                end
            end
            A_WR: begin
                acc_n    = A_IDLE;
                wr_ack_n = 1'b1;
                addr_n   = addr + AW'(1);
                if (mode_q == RECORD && addr == LAST) begin
                    mode_n = IDLE;
                    end_n  = LAST;
                end
            end
            A_RD1: acc_n = A_RD2;
            A_RD2: begin
                acc_n = A_IDLE;
                if ((mode_q == PLAY || mode_q == PAUSE) && !stop_e) begin
                    speed_adv = 1'b1;
                    if (next_ptr >= {1'b0, end_addr}) begin
                        play_done = 1'b1;
                        mode_n    = IDLE;
                        addr_n    = '0;
                    end else begin
                        addr_n = next_ptr[AW-1:0];
                    end
                end else if (mode_q == IDLE) begin
                    addr_n = '0;
                end
            end
            default: acc_n = A_IDLE;
        endcase

        if (acc_q != A_IDLE && req_m && !pending_q) begin
            pending_n = 1'b1;
        end

        // A read caught by stop in its first strobe cycle zeroes addr once it ends.
        case (mode_q)
            IDLE: begin
                if (stop_e) begin
                    mode_n = IDLE;
                end else if (rec_e) begin
                    mode_n = RECORD;
                    addr_n = '0;
                end else if (play_e && end_addr != '0) begin
                    mode_n      = PLAY;
                    addr_n      = '0;
                    speed_clear = 1'b1;
                end
            end
            RECORD: begin
                if (stop_e) begin
                    mode_n = IDLE;
                    if (acc_q == A_WR) begin
                        end_n = (addr == LAST) ? LAST : addr + AW'(1);
                    end else begin
                        end_n = addr;
                    end
                end
            end
            PLAY, PAUSE: begin
                if (stop_e) begin
                    mode_n = IDLE;
                    if (acc_q != A_RD1) begin
                        addr_n = '0;
                    end
                end else if (play_e && !play_done) begin
                    mode_n = (mode_q == PLAY) ? PAUSE : PLAY;
                end
            end
            default: mode_n = IDLE;
        endcase

        if (mode_n != mode_q) begin
            pending_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q     <= '0;
            btn_prev  <= '0;
            mode_q    <= IDLE;
            acc_q     <= A_IDLE;
            pending_q <= 1'b0;
            addr      <= '0;
            end_addr  <= '0;
            wr_ack    <= 1'b0;
        end else begin
            btn_q     <= {btn_record, btn_play, btn_stop};
            btn_prev  <= btn_q;
            mode_q    <= mode_n;
            acc_q     <= acc_n;
            pending_q <= pending_n;
            addr      <= addr_n;
            end_addr  <= end_n;
            wr_ack    <= wr_ack_n;
        end
    end

    assign mode    = mode_q;
    assign sram_we = (acc_q == A_WR);
    assign sram_oe = (acc_q == A_RD1) || (acc_q == A_RD2);
    assign rd_ack  = (acc_q == A_RD2);

endmodule

// File: tb/tb_transport_ctrl.sv
// Self-checking bench for transport_ctrl: scenario tasks against a behavioural
// model of recording length and playback address sequences.
module tb_transport_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          btn_record, btn_play, btn_stop;
    logic [3:0]    fast, slow;
    logic          wr_req, rd_req;
    logic          wr_ack, rd_ack;
    logic [AW-1:0] addr;
    logic          sram_we, sram_oe;
    logic [1:0]    mode;
    logic [AW-1:0] end_addr;
    logic          play_done;

    int vectors     = 0;
    int miscompares = 0;

    int wr_log[$];
    int rd_log[$];
    int exp_reads[$];
    int wr_ack_cnt = 0;
    int done_cnt   = 0;
    int done_bad   = 0;
    int oe_cnt     = 0;
    int unstable   = 0;
    logic          prev_oe = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    transport_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_record (btn_record),
        .btn_play   (btn_play),
        .btn_stop   (btn_stop),
        .fast       (fast),
        .slow       (slow),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .wr_ack     (wr_ack),
        .rd_ack     (rd_ack),
        .addr       (addr),
        .sram_we    (sram_we),
        .sram_oe    (sram_oe),
        .mode       (mode),
        .end_addr   (end_addr),
        .play_done  (play_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sram_we) wr_log.push_back(int'(addr));
        if (rd_ack) rd_log.push_back(int'(addr));
        if (wr_ack) wr_ack_cnt++;
        if (sram_oe) oe_cnt++;
        if (play_done) begin
            done_cnt++;
            if (!rd_ack) done_bad++;
        end
        if (sram_oe && prev_oe && addr != prev_addr) unstable++;
        prev_oe   = sram_oe;
        prev_addr = addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic r, input logic p, input logic s);
        btn_record = r;
        btn_play   = p;
        btn_stop   = s;
        repeat (3) tick();
        btn_record = 1'b0;
        btn_play   = 1'b0;
        btn_stop   = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wr_pulse(input int gap);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic rd_pulse(input int gap);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_record(input int n, input int gap);
        wr_log.delete();
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) wr_pulse(gap);
        if (mode == 2'd1) press(1'b0, 1'b0, 1'b1);
    endtask

    // Reference playback sequence straight from the rate rules.
    task automatic build_expected(input int endv, input int f, input int s);
        int fn, sn, pos, k;
        fn  = (f == 0 || f > 8) ? 1 : f;
        sn  = (s == 0 || s > 8) ? 1 : s;
        pos = 0;
        k   = 0;
        exp_reads.delete();
        while (pos < endv) begin
            exp_reads.push_back(pos);
            k++;
            if (fn > 1) pos += fn;
            else if (sn > 1) pos += (k % sn == 0) ? 1 : 0;
            else pos += 1;
        end
    endtask

    task automatic run_play(input int endv, input logic [3:0] f, input logic [3:0] s, input string tag);
        int n, bad;
        build_expected(endv, int'(f), int'(s));
        fast = f;
        slow = s;
        rd_log.delete();
        done_cnt = 0;
        done_bad = 0;
        press(1'b0, 1'b1, 1'b0);
        n = 0;
        while (mode == 2'd2 && n < 400) begin
            rd_pulse(3);
            n++;
        end
        vectors++;
        if (rd_log.size() != exp_reads.size()) begin
            miscompares++;
            $display("[TB] FAIL %s read count: got %0d expected %0d", tag, rd_log.size(), exp_reads.size());
        end
        bad = 0;
        for (int i = 0; i < exp_reads.size() && i < rd_log.size(); i++)
            if (rd_log[i] != exp_reads[i]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL %s read addresses: %0d wrong, expected 0 wrong", tag, bad);
        end
        vectors++;
        if (done_cnt != 1 || done_bad != 0) begin
            miscompares++;
            $display("[TB] FAIL %s play_done: got %0d pulses (%0d without ack) expected 1 (0)", tag, done_cnt, done_bad);
        end
        vectors++;
        if (mode !== 2'd0 || addr !== '0) begin
            miscompares++;
            $display("[TB] FAIL %s end state: mode %0d addr %0d expected 0 0", tag, mode, addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {btn_record, btn_play, btn_stop, wr_req, rd_req} = '0;
        fast = 4'd1;
        slow = 4'd1;
        repeat (2) tick();
        vectors++;
        if (mode !== 2'd0 || addr !== '0 || end_addr !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset regs: mode %0d addr %0d end %0d expected 0 0 0", mode, addr, end_addr);
        end
        vectors++;
        if ({sram_we, sram_oe, wr_ack, rd_ack, play_done} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset strobes: got %b expected 00000", {sram_we, sram_oe, wr_ack, rd_ack, play_done});
        end
        reset = 1'b1;
        tick();
        press(1'b0, 1'b1, 1'b0);
        vectors++;
        if (mode !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL play with empty recording: mode %0d expected 0", mode);
        end
    endtask

    task automatic test_record_stop();
        btn_record = 1'b1;
        tick();
        vectors++;
        if (mode !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL mode latency early: mode %0d expected 0", mode);
        end
        tick();
        vectors++;
        if (mode !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL mode latency: mode %0d expected 1", mode);
        end
        btn_record = 1'b0;
        repeat (2) tick();
        wr_log.delete();
        wr_ack_cnt = 0;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        vectors++;
        if (sram_we !== 1'b1 || wr_ack !== 1'b0 || addr !== AW'(0)) begin
            miscompares++;
            $display("[TB] FAIL write t+1: we %b ack %b addr %0d expected 1 0 0", sram_we, wr_ack, addr);
        end
        tick();
        vectors++;
        if (sram_we !== 1'b0 || wr_ack !== 1'b1 || addr !== AW'(1)) begin
            miscompares++;
            $display("[TB] FAIL write t+2: we %b ack %b addr %0d expected 0 1 1", sram_we, wr_ack, addr);
        end
        repeat (2) tick();
        for (int i = 1; i < 5; i++) wr_pulse(3);
        vectors++;
        if (wr_log.size() != 5 || wr_log[0] != 0 || wr_log[4] != 4 || wr_ack_cnt != 5) begin
            miscompares++;
            $display("[TB] FAIL record writes: got %0d writes %0d acks expected 5 5 at 0..4", wr_log.size(), wr_ack_cnt);
        end
        press(1'b0, 1'b0, 1'b1);
        vectors++;
        if (end_addr !== AW'(5) || mode !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL stop: end_addr %0d mode %0d expected 5 0", end_addr, mode);
        end
    endtask

    task automatic test_play_basic();
        logic [3:0] unity[4];
        unity[0] = 4'd0;
        unity[1] = 4'd1;
        unity[2] = 4'($urandom_range(9, 15));
        unity[3] = 4'd1;
        fast = unity[$urandom_range(0, 3)];
        slow = unity[$urandom_range(0, 3)];
        rd_log.delete();
        done_cnt = 0;
        done_bad = 0;
        press(1'b0, 1'b1, 1'b0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        vectors++;
        if (sram_oe !== 1'b1 || rd_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read t+1: oe %b ack %b expected 1 0", sram_oe, rd_ack);
        end
        tick();
        vectors++;
        if (sram_oe !== 1'b1 || rd_ack !== 1'b1 || addr !== AW'(0)) begin
            miscompares++;
            $display("[TB] FAIL read t+2: oe %b ack %b addr %0d expected 1 1 0", sram_oe, rd_ack, addr);
        end
        tick();
        vectors++;
        if (sram_oe !== 1'b0 || addr !== AW'(1)) begin
            miscompares++;
            $display("[TB] FAIL read t+3: oe %b addr %0d expected 0 1", sram_oe, addr);
        end
        tick();
        for (int i = 1; i < 5; i++) rd_pulse(3);
        vectors++;
        if (rd_log.size() != 5 || rd_log[0] != 0 || rd_log[4] != 4) begin
            miscompares++;
            $display("[TB] FAIL play reads: got %0d reads expected 5 at 0..4", rd_log.size());
        end
        vectors++;
        if (done_cnt != 1 || done_bad != 0 || mode !== 2'd0 || addr !== '0) begin
            miscompares++;
            $display("[TB] FAIL play end: done %0d mode %0d addr %0d expected 1 0 0", done_cnt, mode, addr);
        end
    endtask

    task automatic test_rates();
        int len;
        do_record(20, 3);
        vectors++;
        if (end_addr !== AW'(20)) begin
            miscompares++;
            $display("[TB] FAIL record 20: end_addr %0d expected 20", end_addr);
        end
        run_play(20, 4'd3, 4'd1, "fast3");
        run_play(20, 4'd1, 4'd2, "slow2");
        for (int k = 0; k < 4; k++) begin
            len = $urandom_range(5, 30);
            do_record(len, $urandom_range(2, 5));
            vectors++;
            if (end_addr !== AW'(len)) begin
                miscompares++;
                $display("[TB] FAIL random record: end_addr %0d expected %0d", end_addr, len);
            end
            run_play(len, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("[TB] FAIL addr stability: %0d changes during oe expected 0", unstable);
        end
    endtask

    task automatic test_pause();
        do_record(20, 2);
        build_expected(20, 1, 2);
        fast = 4'd1;
        slow = 4'd2;
        rd_log.delete();
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) rd_pulse(3);
        press(1'b0, 1'b1, 1'b0);
        vectors++;
        if (mode !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL pause: mode %0d expected 3", mode);
        end
        for (int i = 0; i < 3; i++) rd_pulse(3);
        vectors++;
        if (rd_log.size() != 3 || addr !== AW'(exp_reads[3])) begin
            miscompares++;
            $display("[TB] FAIL paused reads: got %0d reads addr %0d expected 3 %0d", rd_log.size(), addr, exp_reads[3]);
        end
        press(1'b0, 1'b1, 1'b0);
        rd_pulse(3);
        vectors++;
        if (mode !== 2'd2 || rd_log.size() != 4 || rd_log[3] != exp_reads[3] || addr !== AW'(exp_reads[4])) begin
            miscompares++;
            $display("[TB] FAIL resume: mode %0d reads %0d addr %0d expected 2 4 %0d", mode, rd_log.size(), addr, exp_reads[4]);
        end
        press(1'b0, 1'b0, 1'b1);
        vectors++;
        if (mode !== 2'd0 || addr !== '0) begin
            miscompares++;
            $display("[TB] FAIL stop from play: mode %0d addr %0d expected 0 0", mode, addr);
        end
    endtask

    task automatic test_back_to_back();
        press(1'b1, 1'b0, 1'b0);
        wr_log.delete();
        wr_ack_cnt = 0;
        wr_req = 1'b1;
        repeat (3) tick();
        wr_req = 1'b0;
        repeat (5) tick();
        vectors++;
        if (wr_log.size() != 2 || wr_ack_cnt != 2 || addr !== AW'(2)) begin
            miscompares++;
            $display("[TB] FAIL back-to-back: writes %0d acks %0d addr %0d expected 2 2 2", wr_log.size(), wr_ack_cnt, addr);
        end
        oe_cnt = 0;
        rd_pulse(3);
        press(1'b0, 1'b0, 1'b1);
        vectors++;
        if (end_addr !== AW'(2) || oe_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL stop after pending: end %0d stray oe %0d expected 2 0", end_addr, oe_cnt);
        end
        wr_pulse(3);
        rd_pulse(3);
        vectors++;
        if (wr_log.size() != 2 || oe_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL idle drop: writes %0d oe %0d expected 2 0", wr_log.size(), oe_cnt);
        end
    endtask

    task automatic test_coincident();
        press(1'b1, 1'b0, 1'b1);
        tick();
        vectors++;
        if (mode !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL record+stop in idle: mode %0d expected 0", mode);
        end
    endtask

    task automatic test_max_addr();
        do_record(1 << AW, 2);
        vectors++;
        if (mode !== 2'd0 || end_addr !== {AW{1'b1}} || wr_log.size() != (1 << AW)) begin
            miscompares++;
            $display("[TB] FAIL max record: mode %0d end %0d writes %0d expected 0 %0d %0d",
                     mode, end_addr, wr_log.size(), (1 << AW) - 1, 1 << AW);
        end
        vectors++;
        if (wr_log[(1 << AW) - 1] != (1 << AW) - 1) begin
            miscompares++;
            $display("[TB] FAIL last write addr: got %0d expected %0d", wr_log[(1 << AW) - 1], (1 << AW) - 1);
        end
    endtask

    task automatic test_reset_mid_read();
        fast = 4'd1;
        slow = 4'd1;
        press(1'b0, 1'b1, 1'b0);
        rd_log.delete();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        vectors++;
        if (sram_oe !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read before reset: oe %b expected 1", sram_oe);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (sram_oe !== 1'b0 || sram_we !== 1'b0 || rd_ack !== 1'b0 || mode !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL async reset: oe %b we %b ack %b mode %0d expected 0 0 0 0", sram_oe, sram_we, rd_ack, mode);
        end
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if (rd_log.size() != 0 || end_addr !== '0) begin
            miscompares++;
            $display("[TB] FAIL after reset: acks %0d end %0d expected 0 0", rd_log.size(), end_addr);
        end
    endtask

    initial begin
        $display("[TB] transport_ctrl bench start");
        test_reset();
        test_record_stop();
        test_play_basic();
        test_rates();
        test_pause();
        test_back_to_back();
        test_coincident();
        test_max_addr();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
